// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, I-cache miss/redirect FSM and the IF/ID pipeline register.
// branch_target[1:0] are ignored and PC arithmetic wraps modulo 2^32.
module if_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_busy,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [1:0]  if_state
);

  // state    | meaning
  // RUN      | fetching at pc, hits captured every unstalled cycle
  // MISS     | waiting on a miss at miss_addr (== pc), data captured on completion
  // DISCARD  | outstanding miss at miss_addr is stale after a redirect; drop its data
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MISS    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] miss_addr_q, miss_addr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;

  logic [31:0] target;
  logic [31:0] pc_inc;

  assign target = {branch_target[31:2], 2'b00};
  assign pc_inc = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_VECTOR;
      miss_addr_q <= RESET_VECTOR;
      id_pc_q     <= '0;
      id_instr_q  <= '0;
      id_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      miss_addr_q <= miss_addr_d;
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      id_valid_q  <= id_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    miss_addr_d = miss_addr_q;
    id_pc_d     = id_pc_q;
    id_instr_d  = id_instr_q;
    id_valid_d  = id_valid_q;

    case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          pc_d       = target;
          id_valid_d = 1'b0;
          if (imem_busy) begin
            miss_addr_d = pc_q;
            state_d     = ST_DISCARD;
          end
        end else if (imem_busy) begin
          miss_addr_d = pc_q;
          state_d     = ST_MISS;
          // decode consumes the current entry unless stalled, so it becomes a bubble
          if (!stall) id_valid_d = 1'b0;
        end else if (!stall) begin
          id_pc_d    = pc_q;
          id_instr_d = imem_rdata;
          id_valid_d = 1'b1;
          pc_d       = pc_inc;
        end
      end

      ST_MISS: begin
        if (branch_taken) begin
          pc_d       = target;
          id_valid_d = 1'b0;
          state_d    = ST_DISCARD;
        end else if (imem_busy) begin
          if (!stall) id_valid_d = 1'b0;
        end else begin
          state_d = ST_RUN;
          if (!stall) begin
            id_pc_d    = pc_q;
            id_instr_d = imem_rdata;
            id_valid_d = 1'b1;
            pc_d       = pc_inc;
          end
        end
      end

      ST_DISCARD: begin
        if (branch_taken) begin
          pc_d       = target;
          id_valid_d = 1'b0;
        end else if (!stall) begin
          id_valid_d = 1'b0;
        end
        if (!imem_busy) state_d = ST_RUN;
      end

      default: state_d = ST_RUN;
    endcase
  end

  assign imem_read   = ~reset;
  assign imem_addr   = (reset || state_q == ST_RUN) ? pc_q : miss_addr_q;
  assign if_id_pc    = id_pc_q;
  assign if_id_instr = id_instr_q;
  assign if_id_valid = id_valid_q;
  assign if_state    = state_q;

endmodule
